// File: rtl/riscv_mem_pkg.sv
// Shared load/store encodings and lane helpers for the data memory pipeline.
package riscv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   byte_mask = 4'b0001 << off;
         2'b01:   byte_mask = 4'b0011 << off;
         default: byte_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we) f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      else    f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                         (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   // Only meaningful for legal funct3; illegal codes fault regardless.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = off[0];
         default: misaligned = (off != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/data_mem_align.sv
// Load extraction: picks the addressed byte/half from a word and extends it.
module data_mem_align
   import riscv_mem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_func3,
   output logic [31:0] o_rdata
);

   logic [31:0] w_sh;

   assign w_sh = i_word >> {i_off, 3'b000};

   always_comb begin
      o_rdata = w_sh;
      case (i_func3)
         F3_B:    o_rdata = {{24{w_sh[7]}}, w_sh[7:0]};
         F3_H:    o_rdata = {{16{w_sh[15]}}, w_sh[15:0]};
         F3_BU:   o_rdata = {24'h0, w_sh[7:0]};
         F3_HU:   o_rdata = {16'h0, w_sh[15:0]};
         default: o_rdata = w_sh;
      endcase
   end

endmodule

// File: rtl/data_mem_pipe.sv
// Single-cycle data memory with a one-entry response register and byte-lane stores.
module data_mem_pipe
   import riscv_mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_func3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rd_word;
   logic        r_valid;
   logic        r_fault;
   logic        r_load;
   logic [2:0]  r_f3;
   logic [1:0]  r_off;

   logic [31:0]   w_off_addr;
   logic [AW-1:0] w_idx;
   logic          w_range_err;
   logic          w_fault;
   logic          w_accept;
   logic          w_wr_en;
   logic          w_rd_en;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata_rep;
   logic [31:0]   w_ext;

   assign w_off_addr  = req_addr - BASE_ADDR;
   assign w_idx       = w_off_addr[AW+1:2];
   assign w_range_err = (req_addr < BASE_ADDR) || (w_off_addr[31:2] >= 30'(DEPTH_WORDS));
   assign w_fault     = w_range_err || !f3_legal(req_we, req_func3) ||
                        misaligned(req_func3, req_addr[1:0]);

   assign req_ready = !r_valid || rsp_ready;
   // Nothing reaches the array while reset is held, so reset never disturbs contents.
   assign w_accept  = req_valid && req_ready && !rst;
   assign w_wr_en   = w_accept && req_we && !w_fault;
   assign w_rd_en   = w_accept && !req_we && !w_fault;
   assign w_be      = byte_mask(req_func3, req_addr[1:0]);

   always_comb begin
      w_wdata_rep = req_wdata;
      case (req_func3[1:0])
         2'b00:   w_wdata_rep = {4{req_wdata[7:0]}};
         2'b01:   w_wdata_rep = {2{req_wdata[15:0]}};
         default: w_wdata_rep = req_wdata;
      endcase
   end

   // Array and its read register carry no reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
         end
      end
      if (w_rd_en) r_rd_word <= r_mem[w_idx];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_fault <= 1'b0;
         r_load  <= 1'b0;
         r_f3    <= 3'd0;
         r_off   <= 2'd0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_fault <= w_fault;
         r_load  <= !req_we;
         r_f3    <= req_func3;
         r_off   <= req_addr[1:0];
      end else if (rsp_ready) begin
         r_valid <= 1'b0;
      end
   end

   data_mem_align u_align (
      .i_word  (r_rd_word),
      .i_off   (r_off),
      .i_func3 (r_f3),
      .o_rdata (w_ext)
   );

   assign rsp_valid = r_valid;
   assign rsp_fault = r_fault;
   assign rsp_rdata = (r_valid && r_load && !r_fault) ? w_ext : 32'h0;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Scoreboard bench for data_mem_pipe: reference memory model, in-order response queue.
module tb_data_mem_pipe;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          acc_cyc;
      bit          chk_lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_func3 = 3'd0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;

   int          n_err = 0;
   int          n_chk = 0;
   int          cyc = 0;
   exp_t        sb[$];
   logic [31:0] mdl [1024];
   bit          mon_en = 1'b0;

   data_mem_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_func3 (req_func3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_fault (rsp_fault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: BASE 0, 1024 words.
   task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic flt);
      int          size;
      bit          legal;
      int          off;
      int          idx;
      logic [31:0] v;
      off  = int'(addr[1:0]);
      rd   = 32'h0;
      size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      flt  = !legal || ((off % size) != 0) || (addr >= 32'd4096);
      if (!flt) begin
         idx = int'(addr >> 2);
         if (we) begin
            for (int b = 0; b < size; b++) mdl[idx][8*(off+b) +: 8] = wd[8*b +: 8];
         end else begin
            v = mdl[idx] >> (8 * off);
            case (f3)
               3'd0:    rd = {{24{v[7]}}, v[7:0]};
               3'd1:    rd = {{16{v[15]}}, v[15:0]};
               3'd4:    rd = {24'h0, v[7:0]};
               3'd5:    rd = {16'h0, v[15:0]};
               default: rd = v;
            endcase
         end
      end
   endtask

   task automatic send(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit lat);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_func3 = f3;
      req_addr  = addr;
      req_wdata = wd;
      #1;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!req_ready) begin
         chk("req_timeout", 32'd0, 32'd1);
      end else begin
         model(we, f3, addr, wd, e.rdata, e.fault);
         e.acc_cyc = cyc + 1;
         e.chk_lat = lat;
         sb.push_back(e);
         @(posedge clk);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", sb.size(), 32'd0);
   endtask

   always begin
      @(negedge clk);
      #1;
      if (mon_en && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_fault", 32'(rsp_fault), 32'(e.fault));
            if (e.chk_lat) chk("rsp_latency", cyc, e.acc_cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_fault", 32'(rsp_fault), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;

      // word store then load, one-cycle latency
      send(1, 3'd2, 32'h10, 32'hDEADBEEF, 1);
      send(0, 3'd2, 32'h10, 32'h0, 1);
      idle();
      drain();

      // byte store over a known word, store-to-load next cycle
      send(1, 3'd2, 32'h10, 32'h11223344, 0);
      send(1, 3'd0, 32'h13, 32'h00000080, 0);
      send(0, 3'd0, 32'h13, 32'h0, 0);
      send(0, 3'd4, 32'h13, 32'h0, 0);
      send(0, 3'd2, 32'h10, 32'h0, 0);
      send(0, 3'd1, 32'h12, 32'h0, 0);
      send(0, 3'd5, 32'h12, 32'h0, 0);
      idle();
      drain();

      // faults: misaligned, illegal funct3; memory untouched
      send(1, 3'd1, 32'h11, 32'h0000FFFF, 0);
      send(0, 3'd2, 32'h12, 32'h0, 0);
      send(0, 3'd3, 32'h10, 32'h0, 0);
      send(1, 3'd4, 32'h10, 32'hFFFFFFFF, 0);
      send(0, 3'd2, 32'h10, 32'h0, 0);
      send(1, 3'd1, 32'h12, 32'h0000BEEF, 0);
      send(0, 3'd1, 32'h12, 32'h0, 0);
      send(0, 3'd0, 32'h11, 32'h0, 0);
      idle();
      drain();

      // range boundary
      send(1, 3'd2, 32'hFFC, 32'hCAFEF00D, 0);
      send(0, 3'd2, 32'hFFC, 32'h0, 0);
      send(0, 3'd2, 32'h1000, 32'h0, 0);
      send(1, 3'd2, 32'h1000, 32'h12345678, 0);
      send(0, 3'd2, 32'hFFC, 32'h0, 0);
      idle();
      drain();

      // 8 back-to-back loads with a 3-cycle consumer stall
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               logic [2:0] f3s [4];
               f3s[0] = 3'd2; f3s[1] = 3'd0; f3s[2] = 3'd5; f3s[3] = 3'd4;
               if (i % 2 == 0) send(0, f3s[i % 4], 32'h10 + 32'(i % 4), 32'h0, 0);
               else            send(0, f3s[i % 4], 32'hFFC + 32'((i % 2) * 2), 32'h0, 0);
            end
         end
         begin
            repeat (3) @(negedge clk);
            rsp_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               #1;
               chk("stall_ready", 32'(req_ready), 32'd0);
               @(negedge clk);
            end
            rsp_ready = 1'b1;
         end
      join
      idle();
      drain();

      // reset with a response pending
      @(negedge clk);
      rsp_ready = 1'b0;
      send(0, 3'd2, 32'h10, 32'h0, 0);
      idle();
      #1;
      chk("pend_valid", 32'(rsp_valid), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(rsp_valid), 32'd0);
      chk("arst_rdata", rsp_rdata, 32'h0);
      chk("arst_ready", 32'(req_ready), 32'd1);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      rsp_ready = 1'b1;
      send(0, 3'd2, 32'h10, 32'h0, 0);
      send(0, 3'd2, 32'hFFC, 32'h0, 0);
      idle();
      drain();

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
